// File: rtl/aurora_rx_pattern_checker.sv
// rtl/aurora_rx_pattern_checker.sv - incrementing-counter pattern checker for the Aurora RX user stream
//
// Watches the Aurora lane's user-side RX stream and checks that valid beats
// follow an incrementing counter. Lock is acquired after LOCK_WORDS
// consecutive counting beats and dropped after LOSS_WORDS consecutive
// mismatches while locked. Mismatches while locked, and a channel drop while
// locked, bump a sticky saturating error counter. Frames (rx_tlast beats)
// are counted while locked.
//
// Ports:
//   user_clk            in   Aurora user clock, all logic on its rising edge
//   peripheral_aresetn  in   synchronous active-low reset
//   channel_up          in   Aurora channel-up status
//   rx_tdata            in   received beat data (DATA_WIDTH)
//   rx_tvalid           in   beat valid; no back-pressure, every beat consumed
//   rx_tlast            in   end-of-frame marker, qualified by rx_tvalid
//   clear_errors        in   single-cycle pulse that zeroes Error_Counter
//   Error_Counter       out  sticky saturating error count (ERR_CNT_WIDTH)
//   locked              out  high while pattern lock is held
//   frame_count         out  frames received while locked, wraps at 16 bits

module aurora_rx_pattern_checker #(
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 4,
    parameter int LOCK_WORDS    = 4,
    parameter int LOSS_WORDS    = 4
) (
    input  logic                     user_clk,
    input  logic                     peripheral_aresetn,
    input  logic                     channel_up,
    input  logic [DATA_WIDTH-1:0]    rx_tdata,
    input  logic                     rx_tvalid,
    input  logic                     rx_tlast,
    input  logic                     clear_errors,
    output logic [ERR_CNT_WIDTH-1:0] Error_Counter,
    output logic                     locked,
    output logic [15:0]              frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    // Run lengths never exceed 255, so 8-bit run counters are sufficient.
    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_WORDS);
    localparam logic [7:0] LOSS_LIMIT = 8'(LOSS_WORDS);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

    state_e                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    expected_q, expected_d;
    logic [7:0]               good_run_q, good_run_d;
    logic [7:0]               bad_run_q, bad_run_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                     locked_q, locked_d;
    logic [15:0]              frame_cnt_q, frame_cnt_d;

    logic                     match;
    logic                     err_event;
    logic [7:0]               good_next;
    logic [7:0]               bad_next;

    assign match = (rx_tdata == expected_q);

    always_ff @(posedge user_clk) begin
        if (!peripheral_aresetn) begin
            state_q     <= ST_IDLE;
            expected_q  <= '0;
            good_run_q  <= '0;
            bad_run_q   <= '0;
            err_cnt_q   <= '0;
            locked_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            good_run_q  <= good_run_d;
            bad_run_q   <= bad_run_d;
            err_cnt_q   <= err_cnt_d;
            locked_q    <= locked_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        good_run_d  = good_run_q;
        bad_run_d   = bad_run_q;
        frame_cnt_d = frame_cnt_q;
        err_event   = 1'b0;
        good_next   = good_run_q + 8'd1;
        bad_next    = bad_run_q + 8'd1;

        if (!channel_up) begin
            // Link loss takes priority over any beat presented this cycle.
            state_d = ST_IDLE;
            if (state_q == ST_LOCKED) begin
                err_event = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // good_run == 0 marks "no beat seen yet" in ACQUIRE.
                    state_d    = ST_ACQUIRE;
                    good_run_d = '0;
                    bad_run_d  = '0;
                end

                ST_ACQUIRE: begin
                    if (rx_tvalid) begin
                        if ((good_run_q != 8'd0) && match) begin
                            expected_d = expected_q + 1'b1;
                        end else begin
                            expected_d = rx_tdata + 1'b1;
                            good_next  = 8'd1;
                        end
                        good_run_d = good_next;
                        if (good_next == LOCK_LIMIT) begin
                            state_d    = ST_LOCKED;
                            good_run_d = '0;
                            bad_run_d  = '0;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (rx_tvalid) begin
                        if (match) begin
                            expected_d = expected_q + 1'b1;
                            bad_run_d  = '0;
                        end else begin
                            // Resync to the received value so one corrupt
                            // beat costs exactly one error.
                            err_event  = 1'b1;
                            expected_d = rx_tdata + 1'b1;
                            bad_run_d  = bad_next;
                            if (bad_next == LOSS_LIMIT) begin
                                state_d    = ST_ACQUIRE;
                                good_run_d = '0;
                                bad_run_d  = '0;
                            end
                        end
                        if (rx_tlast) begin
                            frame_cnt_d = frame_cnt_q + 16'd1;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Clear wins over a coincident error; the counter holds at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clear_errors) begin
            err_cnt_d = '0;
        end else if (err_event && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    assign locked_d      = (state_d == ST_LOCKED);
    assign Error_Counter = err_cnt_q;
    assign locked        = locked_q;
    assign frame_count   = frame_cnt_q;

endmodule

// File: tb/tb_aurora_rx_pattern_checker.sv
// tb/tb_aurora_rx_pattern_checker.sv - self-checking bench for aurora_rx_pattern_checker
module tb_aurora_rx_pattern_checker;

    localparam int LOCK = 4;
    localparam int LOSS = 4;

    logic        user_clk = 1'b0;
    logic        rstn;
    logic        chan;
    logic [31:0] data;
    logic        valid;
    logic        last;
    logic        clr;
    logic [3:0]  err;
    logic        lk;
    logic [15:0] frames;

    int checks   = 0;
    int failures = 0;

    // Reference model state: one counted beat always leaves the next
    // expected value at data+1, whether it matched or not.
    logic [31:0] m_exp;
    logic [15:0] m_frames;
    int          m_err;
    int          m_good;
    int          m_bad;
    bit          m_hunting;
    bit          m_lockd;

    always #5 user_clk = ~user_clk;

    aurora_rx_pattern_checker #(
        .DATA_WIDTH(32), .ERR_CNT_WIDTH(4), .LOCK_WORDS(LOCK), .LOSS_WORDS(LOSS)
    ) dut (
        .user_clk(user_clk), .peripheral_aresetn(rstn), .channel_up(chan),
        .rx_tdata(data), .rx_tvalid(valid), .rx_tlast(last),
        .clear_errors(clr), .Error_Counter(err), .locked(lk), .frame_count(frames)
    );

    typedef struct {
        bit          c;
        bit          v;
        logic [31:0] d;
        bit          l;
        bit          k;
        logic [3:0]  e_err;
        bit          e_lk;
        logic [15:0] e_frm;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_exp = '0; m_frames = '0; m_err = 0; m_good = 0; m_bad = 0;
        m_hunting = 1'b0; m_lockd = 1'b0;
    endtask

    task automatic model_step(input bit c, input bit v, input logic [31:0] d,
                              input bit l, input bit k);
        bit err_ev;
        err_ev = 1'b0;
        if (!c) begin
            if (m_lockd) err_ev = 1'b1;
            m_lockd = 1'b0;
            m_hunting = 1'b0;
        end else if (!m_lockd && !m_hunting) begin
            m_hunting = 1'b1;
            m_good = 0;
        end else if (v) begin
            if (m_hunting) begin
                if (m_good > 0 && d == m_exp) m_good++;
                else m_good = 1;
                if (m_good == LOCK) begin
                    m_hunting = 1'b0; m_lockd = 1'b1; m_bad = 0;
                end
            end else begin
                if (d == m_exp) m_bad = 0;
                else begin
                    err_ev = 1'b1;
                    m_bad++;
                end
                if (l) m_frames = m_frames + 16'd1;
                if (m_bad == LOSS) begin
                    m_lockd = 1'b0; m_hunting = 1'b1; m_good = 0;
                end
            end
            m_exp = d + 32'd1;
        end
        if (k) m_err = 0;
        else if (err_ev && m_err < 15) m_err++;
    endtask

    task automatic step(input bit c, input bit v, input logic [31:0] d,
                        input bit l, input bit k);
        chan = c; valid = v; data = d; last = l; clr = k;
        @(posedge user_clk);
        if (rstn) model_step(c, v, d, l, k);
        else model_reset();
        #1;
    endtask

    task automatic check_model(input string name);
        check({name, ".err"}, 32'(err), 32'(m_err));
        check({name, ".locked"}, 32'(lk), 32'(m_lockd));
        check({name, ".frames"}, 32'(frames), 32'(m_frames));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, $urandom, 1'b1, 1'b1);
        rstn = 1'b1;
    endtask

    task automatic count_up(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, base + 32'(i), 1'b0, 1'b0);
    endtask

    initial begin
        rstn = 1'b0; chan = 1'b0; data = '0; valid = 1'b0; last = 1'b0; clr = 1'b0;
        model_reset();

        //          c  v  data         l  k  err   lk frames
        tbl[0]  = '{1, 0, 32'h0,       0, 0, 4'd0, 0, 16'd0};
        tbl[1]  = '{1, 1, 32'h10,      0, 0, 4'd0, 0, 16'd0};
        tbl[2]  = '{1, 1, 32'h11,      0, 0, 4'd0, 0, 16'd0};
        tbl[3]  = '{1, 1, 32'h12,      0, 0, 4'd0, 0, 16'd0};
        tbl[4]  = '{1, 1, 32'h13,      0, 0, 4'd0, 1, 16'd0};
        tbl[5]  = '{1, 1, 32'h14,      0, 0, 4'd0, 1, 16'd0};
        tbl[6]  = '{1, 1, 32'h99,      0, 0, 4'd1, 1, 16'd0};
        tbl[7]  = '{1, 1, 32'h9A,      0, 0, 4'd1, 1, 16'd0};
        tbl[8]  = '{1, 0, 32'h55,      1, 0, 4'd1, 1, 16'd0};
        tbl[9]  = '{1, 1, 32'h9B,      1, 0, 4'd1, 1, 16'd1};
        tbl[10] = '{1, 0, 32'h0,       0, 1, 4'd0, 1, 16'd1};

        do_reset();
        check("reset.err", 32'(err), 32'd0);
        check("reset.locked", 32'(lk), 32'd0);
        check("reset.frames", 32'(frames), 32'd0);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].k);
            check($sformatf("vec%0d.err", i), 32'(err), 32'(tbl[i].e_err));
            check($sformatf("vec%0d.locked", i), 32'(lk), 32'(tbl[i].e_lk));
            check($sformatf("vec%0d.frames", i), 32'(frames), 32'(tbl[i].e_frm));
        end

        // Four non-counting beats while locked: lock lost on the fourth.
        step(1, 1, 32'h1000, 0, 0);
        step(1, 1, 32'h2000, 0, 0);
        step(1, 1, 32'h3000, 0, 0);
        check("loss.locked_after3", 32'(lk), 32'd1);
        step(1, 1, 32'h4000, 0, 0);
        check("loss.locked_after4", 32'(lk), 32'd0);
        check("loss.err", 32'(err), 32'd4);
        count_up(32'h500, 3);
        check("relock.after3", 32'(lk), 32'd0);
        count_up(32'h503, 1);
        check("relock.after4", 32'(lk), 32'd1);
        check("relock.err", 32'(err), 32'd4);

        // Isolated corrupt beats, each followed by a good one: saturation.
        for (int i = 0; i < 20; i++) begin
            step(1, 1, m_exp ^ 32'h8000_0000, 0, 0);
            step(1, 1, m_exp, 0, 0);
        end
        check("sat.err", 32'(err), 32'd15);
        check("sat.locked", 32'(lk), 32'd1);
        step(1, 1, m_exp ^ 32'h0000_0100, 0, 1);
        check("clear_vs_error.err", 32'(err), 32'd0);
        check("clear_vs_error.locked", 32'(lk), 32'd1);
        step(1, 1, m_exp, 0, 0);
        check("after_clear.err", 32'(err), 32'd0);

        // Channel drop while locked: one error, beat in that cycle ignored.
        step(0, 1, m_exp, 1, 0);
        check("drop.err", 32'(err), 32'd1);
        check("drop.locked", 32'(lk), 32'd0);
        check("drop.frames", 32'(frames), 32'd1);
        step(1, 1, 32'h6FF, 0, 0);
        count_up(32'h700, 3);
        check("drop_relock.after3", 32'(lk), 32'd0);
        count_up(32'h703, 1);
        check("drop_relock.after4", 32'(lk), 32'd1);
        check("drop_relock.err", 32'(err), 32'd1);
        check_model("handseq");

        // Reset mid-operation with clear and channel_up asserted.
        do_reset();
        check("midreset.err", 32'(err), 32'd0);
        check("midreset.locked", 32'(lk), 32'd0);
        check("midreset.frames", 32'(frames), 32'd0);

        // Counter wrap at all-ones.
        step(1, 0, 32'h0, 0, 0);
        count_up(32'hFFFF_FFFA, 4);
        check("wrap.locked", 32'(lk), 32'd1);
        step(1, 1, 32'hFFFF_FFFE, 0, 0);
        step(1, 1, 32'hFFFF_FFFF, 0, 0);
        step(1, 1, 32'h0000_0000, 1, 0);
        check("wrap.err", 32'(err), 32'd0);
        check("wrap.frames", 32'(frames), 32'd1);
        step(1, 1, 32'h0000_0001, 0, 0);
        check("wrap.next_err", 32'(err), 32'd0);
        check("wrap.next_locked", 32'(lk), 32'd1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            bit          c, v, l, k;
            logic [31:0] d;
            c = ($urandom_range(0, 59) != 0);
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 4) != 0) ? m_exp : $urandom;
            l = ($urandom_range(0, 7) == 0);
            k = ($urandom_range(0, 63) == 0);
            step(c, v, d, l, k);
            check_model($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aurora_rx_pattern_checker.md
Name: aurora_rx_pattern_checker

Overview:
- Downstream consumer of the Aurora 8b/10b lane's user-side AXI4-Stream RX interface inside the channel tester.
- Checks that received beats follow an incrementing-counter pattern, acquires and tracks pattern lock, and maintains a sticky saturating error counter and a frame counter.
- Its Error_Counter output drives the tester's top-level Error_Counter_0 pin; channel_up comes from the Aurora core.

Parameters:
- DATA_WIDTH, 32, width of rx_tdata and of the expected-pattern register.
- ERR_CNT_WIDTH, 4, width of Error_Counter; the counter saturates at all-ones.
- LOCK_WORDS, 4, consecutive matching beats needed to enter LOCKED (range 2..255).
- LOSS_WORDS, 4, consecutive mismatching beats in LOCKED that force a return to ACQUIRE (range 2..255).

Ports:
- user_clk  input  1  Aurora user clock; all logic is on its rising edge.
- peripheral_aresetn  input  1  synchronous, active-low reset.
- channel_up  input  1  Aurora channel-up status.
- rx_tdata  input  DATA_WIDTH  received beat data.
- rx_tvalid  input  1  beat valid; there is no tready, so every valid beat must be consumed.
- rx_tlast  input  1  end-of-frame marker, qualified by rx_tvalid.
- clear_errors  input  1  single-cycle pulse that zeroes Error_Counter.
- Error_Counter  output  ERR_CNT_WIDTH  sticky saturating error count, registered.
- locked  output  1  high while in LOCKED, registered.
- frame_count  output  16  frames received while LOCKED; wraps at 16 bits, registered.

Behaviour:
- Reset (peripheral_aresetn=0 at a clock edge):
  - state goes to IDLE.
  - Error_Counter=0, locked=0, frame_count=0, expected=0, good_run=0, bad_run=0.
- "beat": rx_tvalid=1 on a clock edge. "match": rx_tdata == expected. expected always advances modulo 2^DATA_WIDTH (all-ones wraps to 0).
- IDLE:
  - Beats are ignored.
  - If channel_up=1, go to ACQUIRE.
- ACQUIRE:
  - First beat after entry: expected<=rx_tdata+1, good_run<=1.
  - Later beats on a match: expected<=expected+1, good_run<=good_run+1.
  - Later beats on a mismatch: expected<=rx_tdata+1, good_run<=1.
  - When good_run reaches LOCK_WORDS, go to LOCKED and clear bad_run.
  - With the default parameter, 4 consecutive counting beats (first included) give locked=1 on the cycle after the 4th beat's edge.
  - No errors are counted in ACQUIRE.
- LOCKED:
  - Match: expected<=expected+1, bad_run<=0.
  - Mismatch: Error_Counter increments (saturating), expected<=rx_tdata+1 (resync), bad_run<=bad_run+1.
  - When bad_run reaches LOSS_WORDS, go to ACQUIRE and restart acquisition.
  - A beat with rx_tlast=1 increments frame_count, whether or not it matched.
- Loss of link, from any state:
  - channel_up=0 sends the block to IDLE on the next edge.
  - If the state was LOCKED, Error_Counter increments once (link drop counts as one error).
  - A beat in that same cycle is ignored.
- Latency: every output updates on the clock edge that samples the causing beat, so it is visible one cycle after the beat is presented.
- Saturation: at all-ones, Error_Counter stays put; further errors are dropped.
- Simultaneous clear_errors and an error in the same cycle: clear wins and Error_Counter=0.
- clear_errors does not affect state, locked or frame_count.
- Reset mid-operation: reset overrides all other inputs, including clear_errors and channel_up.
- rx_tvalid=0 cycles (gaps) do not break the pattern or any run counter.

Test Plan:
- Reset low 5 cycles, channel_up=1, then beats 0x10,0x11,0x12,0x13 -> locked=1 after the 4th beat; Error_Counter=0.
- Locked at expected=0x14, send 0x14,0x99,0x9A -> Error_Counter=1, no further errors, locked stays 1.
- Locked, send 4 random non-counting beats -> Error_Counter=4, locked=0 after the 4th; then 4 counting beats -> locked=1 again.
- Locked, send 20 isolated corrupt beats separated by good beats -> Error_Counter saturates at 15; clear_errors pulse -> 0.
- Locked, drop channel_up for 1 cycle -> Error_Counter +1 and locked=0; re-raise, send 4 counting beats -> locked=1.
- Locked at expected=0xFFFFFFFE, send 0xFFFFFFFE,0xFFFFFFFF,0x00000000 with tlast on the last beat -> no errors, frame_count=1.
